// File: rtl/ascon_round_pkg.sv
// Shared types, default round counts and the round-constant decode for the
// ASCON permutation round sequencer.
package ascon_round_pkg;

   // Permutation mode as presented by the top-level FSM on mode_i
   typedef enum logic [1:0] {
      MODE_A      = 2'd0,
      MODE_B      = 2'd1,
      MODE_C      = 2'd2,
      MODE_CUSTOM = 2'd3
   } mode_e;

   // Sequencer state
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Default round counts: pa/p12, pb/p6 (ASCON-128), pb/p8 (ASCON-128a)
   localparam int ROUNDS_A_DEF = 12;
   localparam int ROUNDS_B_DEF = 6;
   localparam int ROUNDS_C_DEF = 8;

   // Round constant for round index i: high nibble 0xF-i, low nibble i
   function automatic logic [7:0] rc_f(input logic [3:0] index);
      return {4'hF - index, index};
   endfunction

endpackage

// File: rtl/round_sequencer.sv
// ASCON round sequencer: accepts a start with a permutation mode, derives the
// start index from the round count, steps the round index under enable and
// decodes the matching round constant. Rounds always end at NB_ROUNDS_MAX-1,
// so shorter permutations simply start later in the constant table.
module round_sequencer
   import ascon_round_pkg::*;
#(
   parameter int NB_ROUNDS_MAX = 12,
   parameter int ROUNDS_A      = ROUNDS_A_DEF,
   parameter int ROUNDS_B      = ROUNDS_B_DEF,
   parameter int ROUNDS_C      = ROUNDS_C_DEF,
   parameter int CPT_W         = 4
) (
   input  logic             clock_cpt_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [CPT_W-1:0] nb_rounds_i,
   input  logic             enable_i,
   input  logic             abort_i,
   output logic [CPT_W-1:0] counter_o,
   output logic [7:0]       rc_o,
   output logic             busy_o,
   output logic             first_o,
   output logic             last_o,
   output logic             done_o,
   output logic             err_o
);

   // Parameter sanity, evaluated at elaboration
   generate
      if (NB_ROUNDS_MAX < 1 || NB_ROUNDS_MAX > 16) begin : g_bad_depth
         $error("round_sequencer: NB_ROUNDS_MAX must be in 1..16");
      end
      if ((2 ** CPT_W) < NB_ROUNDS_MAX) begin : g_bad_width
         $error("round_sequencer: CPT_W too narrow for NB_ROUNDS_MAX");
      end
   endgenerate

   // One extra bit so custom counts above the table depth can be detected
   localparam logic [CPT_W:0]   NB_MAX_W = (CPT_W+1)'(NB_ROUNDS_MAX);
   localparam logic [CPT_W-1:0] LAST_IDX = CPT_W'(NB_ROUNDS_MAX - 1);

   state_e           state_reg, state_next;
   logic [CPT_W-1:0] counter_reg, counter_next;
   logic [CPT_W-1:0] start_idx_reg, start_idx_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;

   logic [CPT_W:0]   round_cnt;
   logic             round_ok;
   logic [CPT_W-1:0] start_calc;
   logic             at_last;

   // Round count for the requested mode and the resulting start index
   always_comb begin
      round_cnt = '0;
      case (mode_e'(mode_i))
         MODE_A:      round_cnt = (CPT_W+1)'(ROUNDS_A);
         MODE_B:      round_cnt = (CPT_W+1)'(ROUNDS_B);
         MODE_C:      round_cnt = (CPT_W+1)'(ROUNDS_C);
         MODE_CUSTOM: round_cnt = {1'b0, nb_rounds_i};
         default:     round_cnt = '0;
      endcase
      round_ok   = (round_cnt != '0) && (round_cnt <= NB_MAX_W);
      start_calc = CPT_W'(NB_MAX_W - round_cnt);
   end

   assign at_last = (counter_reg == LAST_IDX);

   // State, counter and pulse registers
   always_ff @(posedge clock_cpt_i or negedge reset_i) begin
      if (!reset_i) begin
         state_reg     <= IDLE;
         counter_reg   <= '0;
         start_idx_reg <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         counter_reg   <= counter_next;
         start_idx_reg <= start_idx_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   // Next-state logic; abort outranks start and enable in every state
   always_comb begin
      state_next     = state_reg;
      counter_next   = counter_reg;
      start_idx_next = start_idx_reg;
      done_next      = 1'b0;
      err_next       = 1'b0;
      case (state_reg)
         IDLE: begin
            counter_next = '0;
            if (start_i && !abort_i) begin
               if (round_ok) begin
                  state_next     = RUN;
                  counter_next   = start_calc;
                  start_idx_next = start_calc;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort_i) begin
               state_next   = IDLE;
               counter_next = '0;
            end else if (enable_i) begin
               if (at_last) begin
                  state_next   = IDLE;
                  counter_next = '0;
                  done_next    = 1'b1;
               end else begin
                  counter_next = counter_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next   = IDLE;
            counter_next = '0;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      busy_o    = (state_reg == RUN);
      counter_o = counter_reg;
      first_o   = busy_o && (counter_reg == start_idx_reg);
      last_o    = busy_o && at_last;
      rc_o      = busy_o ? rc_f(4'(counter_reg)) : 8'h00;
      done_o    = done_reg;
      err_o     = err_reg;
   end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Parametrised round sequencer for the ASCON permutation datapath, successor to the fixed p12/p6 round counter. It accepts a start request with a permutation mode (p12, p6, p8 or a custom round count), computes the ASCON start index, steps the round index under a datapath enable, and emits the matching round constant. It reports busy, first-round, last-round and done, and supports abort. It sits between the ASCON top-level FSM and the permutation round logic.

Parameters:
NB_ROUNDS_MAX, 12, total round-constant table depth; the final round index is always NB_ROUNDS_MAX-1; legal range 1..16.
ROUNDS_A, 12, round count for mode A (pa / p12).
ROUNDS_B, 6, round count for mode B (pb / p6, ASCON-128).
ROUNDS_C, 8, round count for mode C (pb / p8, ASCON-128a).
CPT_W, 4, counter width; must satisfy 2**CPT_W >= NB_ROUNDS_MAX.

Ports:
clock_cpt_i  in  1  clock; all logic on rising edge.
reset_i  in  1  reset, asynchronous, active-low.
start_i  in  1  start request; sampled only in IDLE.
mode_i  in  2  0=A, 1=B, 2=C, 3=custom; sampled with start_i.
nb_rounds_i  in  CPT_W  custom round count, used when mode_i=3.
enable_i  in  1  advance permission; the round index steps only when this is 1 in RUN.
abort_i  in  1  synchronous abort.
counter_o  out  CPT_W  current round index i.
rc_o  out  8  round constant for index i.
busy_o  out  1  high in RUN.
first_o  out  1  high in RUN when i equals the start index.
last_o  out  1  high in RUN when i = NB_ROUNDS_MAX-1.
done_o  out  1  one-cycle pulse after the last round is consumed.
err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, reset_i=0): state IDLE; counter 0; start index register 0; all outputs 0, including rc_o=0x00. This applies mid-operation as well; no done_o is produced.
- Round count R: mode A gives ROUNDS_A, B gives ROUNDS_B, C gives ROUNDS_C, custom gives nb_rounds_i. Start index S = NB_ROUNDS_MAX - R.
- States:
  - IDLE: counter 0; busy_o=0.
  - RUN: counter = i, busy_o=1.
- IDLE, start_i=1, R valid (1..NB_ROUNDS_MAX), abort_i=0:
  - next cycle: RUN with counter=S and first_o=1.
  - latency from start to first round is 1 cycle.
- IDLE, start_i=1, R=0 or R>NB_ROUNDS_MAX: stay IDLE; err_o=1 on the next cycle for one cycle.
- RUN, enable_i=0: counter, rc_o and flags hold; this is a stall of any length.
- RUN, enable_i=1, i<NB_ROUNDS_MAX-1: counter increments by 1.
- RUN, enable_i=1, i=NB_ROUNDS_MAX-1 (last_o=1):
  - next cycle: IDLE with counter 0 and done_o=1 for one cycle.
  - a single-round run has first_o and last_o high together.
- abort_i=1:
  - has priority over start_i and enable_i in every state.
  - RUN: next cycle IDLE with counter 0 and no done_o.
  - IDLE: start_i is ignored.
- start_i in RUN is ignored and does not queue.
- A new start is accepted in IDLE, including the cycle in which done_o is high. Back-to-back runs therefore have one idle cycle between them.
- rc_o, when busy_o=1: {4'hF - i[3:0], i[3:0]}. Examples: i=0 gives 0xF0, i=6 gives 0x96, i=11 gives 0x4B.
- rc_o, when busy_o=0: 0x00.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.

Decomposition:
- Shared package ascon_round_pkg contains:
  - mode enum (MODE_A, MODE_B, MODE_C, MODE_CUSTOM);
  - state enum (IDLE, RUN);
  - default round-count constants 12/6/8;
  - function rc_f(index) returning the 8-bit constant.
- No sub-module is needed. FSM, counter and constant decode live in round_sequencer.
- Elaboration-time assertions check the NB_ROUNDS_MAX and CPT_W constraints.

Test Plan:
- Mode A, enable_i held 1, start at cycle T -> busy_o for T+1..T+12; counter 0..11; rc_o 0xF0,0xE1,...,0x4B; first_o at T+1; last_o at T+12; done_o at T+13 only.
- Mode B then mode C, enable_i=1 -> B: counter 6..11, rc_o 0x96..0x4B, done after 6 rounds; C: counter 4..11, first rc_o 0xB4, done after 8 rounds.
- Mode A, enable_i=0 for 3 cycles while counter=8 -> counter 8 and rc_o 0x78 held 4 cycles; total busy cycles = 15; single done_o.
- Custom nb_rounds_i=0 and nb_rounds_i=13 -> err_o pulse, busy_o stays 0. nb_rounds_i=1 -> one RUN cycle at i=11 with first_o=last_o=1, then done_o.
- abort_i at counter=9 in mode A -> IDLE next cycle, counter 0, rc_o 0x00, no done_o. start_i together with abort_i in IDLE -> ignored.
- reset_i low asynchronously mid-run at counter=7 -> all outputs 0 immediately. start_i asserted during RUN -> ignored. start_i during the done_o cycle -> new run begins next cycle.
